counter_mc: RTL and testbench

//   Parametrised successor to the basic load/clear/enable counter.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_presc.sv | 32 +++
 rtl/counter_mc.sv | 106 ++++++++++
 tb/tb_counter_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter_mc timer/event-counter family.
// Boundary-mode and direction encodings are used by the top level and its bench.
package counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // The reserved encoding falls back to wrap, so only SAT and ONESHOT are special.
   function automatic logic is_wrap_mode(input logic [1:0] mode);
      return (mode != MODE_SAT) && (mode != MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/counter_presc.sv
// Prescaler for counter_mc: emits one tick every presc_i+1 enabled cycles.
// A disabled cycle freezes the phase; restart forces the phase back to zero.
module counter_presc #(
   parameter int PWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              restart,
   input  logic [PWIDTH-1:0] presc_i,
   output logic              tick
);

   logic [PWIDTH-1:0] phase_q;
   logic              at_end;

   assign at_end = (phase_q == presc_i);
   assign tick   = en_i && !restart && at_end;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         phase_q <= '0;
      end else if (restart) begin
         phase_q <= '0;
      end else if (en_i) begin
         phase_q <= at_end ? '0 : phase_q + 1'b1;
      end
   end

endmodule

// File: rtl/counter_mc.sv
// Up/down counter with programmable limit, wrap/saturate/one-shot boundary modes,
// prescaler, compare match, terminal-count pulse and sticky overflow flag.
module counter_mc
   import counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int PWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic              en_i,
   input  logic              dir_i,
   input  logic [1:0]        mode_i,
   input  logic [WIDTH-1:0]  lim_i,
   input  logic [WIDTH-1:0]  cmp_i,
   input  logic [PWIDTH-1:0] presc_i,
   input  logic              ovf_clr_i,
   input  logic [WIDTH-1:0]  dat_i,
   output logic [WIDTH-1:0]  dat_o,
   output logic              tc_o,
   output logic              ovf_o,
   output logic              run_o,
   output logic              match_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             run_q, run_d;
   logic             tick;
   logic             step;
   logic             boundary;
   logic             bstep;

   counter_presc #(.PWIDTH(PWIDTH)) u_presc (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .restart (clr_i | we_i),
      .presc_i (presc_i),
      .tick    (tick)
   );

   // tick is already suppressed on clr/we edges, so step never competes with them.
   assign step     = tick && run_q;
   assign boundary = (dir_i == DIR_UP) ? (cnt_q >= lim_i) : (cnt_q == '0);
   assign bstep    = step && boundary;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;

      if (clr_i) begin
         cnt_d = '0;
         run_d = 1'b1;
      end else if (we_i) begin
         cnt_d = (dat_i > lim_i) ? lim_i : dat_i;
         run_d = 1'b1;
      end else if (step) begin
         if (!boundary) begin
            cnt_d = (dir_i == DIR_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
         end else if (is_wrap_mode(mode_i)) begin
            cnt_d = (dir_i == DIR_UP) ? '0 : lim_i;
         end else if (mode_i == MODE_ONESHOT) begin
            run_d = 1'b0;
         end
      end

      // A boundary step on the same edge as ovf_clr_i keeps the flag set.
      if (bstep) begin
         tc_d  = 1'b1;
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   // NOTE: only the small set of control/status registers is reset; there is
   // no storage array here that would need to be left unreset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
         run_q <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
         run_q <= run_d;
      end
   end

   assign dat_o   = cnt_q;
   assign tc_o    = tc_q;
   assign ovf_o   = ovf_q;
   assign run_o   = run_q;
   assign match_o = (cnt_q == cmp_i);

endmodule

// File: tb/tb_counter_mc.sv
// Directed self-checking bench for counter_mc with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_mc;
   import counter_pkg::*;

   localparam int WIDTH  = 8;
   localparam int PWIDTH = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              clr_i, we_i, en_i, dir_i, ovf_clr_i;
   logic [1:0]        mode_i;
   logic [WIDTH-1:0]  lim_i, cmp_i, dat_i;
   logic [PWIDTH-1:0] presc_i;
   logic [WIDTH-1:0]  dat_o;
   logic              tc_o, ovf_o, run_o, match_o;

   int tests  = 0;
   int failed = 0;

   counter_mc #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .we_i      (we_i),
      .en_i      (en_i),
      .dir_i     (dir_i),
      .mode_i    (mode_i),
      .lim_i     (lim_i),
      .cmp_i     (cmp_i),
      .presc_i   (presc_i),
      .ovf_clr_i (ovf_clr_i),
      .dat_i     (dat_i),
      .dat_o     (dat_o),
      .tc_o      (tc_o),
      .ovf_o     (ovf_o),
      .run_o     (run_o),
      .match_o   (match_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b0; clr_i = 1'b0; we_i = 1'b0; en_i = 1'b0; dir_i = DIR_UP;
      ovf_clr_i = 1'b0; mode_i = MODE_WRAP; lim_i = 8'hFF; cmp_i = 8'h00;
      presc_i = '0; dat_i = '0;
      edges(2);
      rst_i = 1'b1;

      // 1. asynchronous reset mid-count
      we_i = 1'b1; dat_i = 8'h37;
      edges(1);
      we_i = 1'b0;
      check("pre_rst_dat", dat_o, 8'h37);
      #2 rst_i = 1'b0;
      #1;
      check("rst_dat", dat_o, 0);
      check("rst_tc", tc_o, 0);
      check("rst_ovf", ovf_o, 0);
      check("rst_run", run_o, 1);
      edges(2);
      check("rst_hold_dat", dat_o, 0);
      rst_i = 1'b1;

      // 2. load, count, load clamped to limit
      we_i = 1'b1; dat_i = 8'hA5; lim_i = 8'hFF;
      edges(1);
      check("load_a5", dat_o, 8'hA5);
      we_i = 1'b0; en_i = 1'b1;
      edges(1);
      check("inc_a6", dat_o, 8'hA6);
      en_i = 1'b0; lim_i = 8'h20; we_i = 1'b1;
      edges(1);
      check("load_clamp", dat_o, 8'h20);
      we_i = 1'b0;

      // 3. wrap mode up and down
      clr_i = 1'b1; lim_i = 8'd9;
      edges(1);
      clr_i = 1'b0;
      check("clr_dat", dat_o, 0);
      en_i = 1'b1;
      edges(9);
      check("wrap_at9", dat_o, 9);
      check("wrap_tc_pre", tc_o, 0);
      check("wrap_ovf_pre", ovf_o, 0);
      edges(1);
      check("wrap_to0", dat_o, 0);
      check("wrap_tc", tc_o, 1);
      check("wrap_ovf", ovf_o, 1);
      edges(1);
      check("wrap_tc_drop", tc_o, 0);
      check("wrap_ovf_sticky", ovf_o, 1);
      en_i = 1'b0; ovf_clr_i = 1'b1;
      edges(1);
      ovf_clr_i = 1'b0;
      check("ovf_cleared", ovf_o, 0);
      clr_i = 1'b1;
      edges(1);
      clr_i = 1'b0;
      dir_i = DIR_DOWN; en_i = 1'b1; ovf_clr_i = 1'b1;
      edges(1);
      en_i = 1'b0; ovf_clr_i = 1'b0;
      check("down_wrap", dat_o, 9);
      check("down_tc", tc_o, 1);
      check("ovf_set_beats_clr", ovf_o, 1);

      // lowered limit: up hits boundary, down decrements normally
      lim_i = 8'hFF; we_i = 1'b1; dat_i = 8'h20;
      edges(1);
      we_i = 1'b0; lim_i = 8'h10; dir_i = DIR_DOWN; en_i = 1'b1;
      edges(1);
      check("lowlim_down", dat_o, 8'h1F);
      dir_i = DIR_UP;
      edges(1);
      check("lowlim_up", dat_o, 0);
      check("lowlim_up_tc", tc_o, 1);
      lim_i = 8'h00; mode_i = 2'd3;
      edges(1);
      check("lim0_dat", dat_o, 0);
      check("lim0_tc", tc_o, 1);
      en_i = 1'b0; mode_i = MODE_WRAP;

      // 4. saturate then one-shot
      ovf_clr_i = 1'b1; clr_i = 1'b1; lim_i = 8'd9;
      edges(1);
      ovf_clr_i = 1'b0; clr_i = 1'b0;
      check("sat_ovf_clr", ovf_o, 0);
      mode_i = MODE_SAT; dir_i = DIR_UP; en_i = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         edges(1);
         check($sformatf("sat_dat_%0d", i), dat_o, (i > 9) ? 9 : i);
         check($sformatf("sat_tc_%0d", i), tc_o, (i >= 10) ? 1 : 0);
      end
      mode_i = MODE_ONESHOT;
      edges(1);
      check("os_dat", dat_o, 9);
      check("os_run", run_o, 0);
      check("os_tc", tc_o, 1);
      dir_i = DIR_DOWN;
      edges(2);
      check("os_ignored_dat", dat_o, 9);
      check("os_ignored_tc", tc_o, 0);
      check("os_ignored_run", run_o, 0);
      we_i = 1'b1; dat_i = 8'd3;
      edges(1);
      we_i = 1'b0;
      check("os_rearm_run", run_o, 1);
      check("os_rearm_dat", dat_o, 3);
      edges(1);
      en_i = 1'b0;
      check("os_rearm_step", dat_o, 2);

      // 5. prescaler divide-by-4 and phase preservation
      mode_i = MODE_WRAP; dir_i = DIR_UP; lim_i = 8'hFF; presc_i = 4'd3; clr_i = 1'b1;
      edges(1);
      clr_i = 1'b0; en_i = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         edges(1);
         check($sformatf("presc_%0d", i), dat_o, i / 4);
      end
      edges(2);
      en_i = 1'b0;
      edges(5);
      check("presc_frozen", dat_o, 4);
      en_i = 1'b1;
      edges(1);
      check("presc_phase3", dat_o, 4);
      edges(1);
      check("presc_resume_tick", dat_o, 5);
      en_i = 1'b0; presc_i = '0;

      // 6. clear beats load; compare match
      clr_i = 1'b1; we_i = 1'b1; dat_i = 8'h11;
      edges(1);
      clr_i = 1'b0; we_i = 1'b0;
      check("clr_beats_we", dat_o, 0);
      cmp_i = 8'd5; en_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         edges(1);
         check($sformatf("match_%0d", i), match_o, (i == 5) ? 1 : 0);
      end
      en_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
